array_20_ctrl: RTL

Request-side controller for the 4096 x 192-bit single-port SRAM array (RW0 port: 12-bit address, 16 x 12-bit write-mask granules, read data valid the cycle after a read enable and held until the next read). It zero-initialises the array after reset, arbitrates a write channel and a read channel onto the single RW0 port, captures read data and returns it in order through a 2-entry response buffer with valid/ready flow control.

---
 rtl/array_20_ctrl_if.sv | 37 +++
 rtl/array_20_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/array_20_ctrl_if.sv
// array_20_ctrl request/response bundle: write channel, read channel and
// in-order read response channel; master = requestor, slave = controller.
interface array_20_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 192,
  parameter int MASK_W = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [MASK_W-1:0] wr_mask;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output wr_valid, wr_addr, wr_mask, wr_data,
    input  wr_ready,
    output rd_valid, rd_addr,
    input  rd_ready,
    input  resp_valid, resp_data,
    output resp_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_mask, wr_data,
    output wr_ready,
    input  rd_valid, rd_addr,
    output rd_ready,
    output resp_valid, resp_data,
    input  resp_ready
  );
endinterface

// File: rtl/array_20_ctrl.sv
// Single-port SRAM request controller: zero-fill sweep, W/R round-robin
// onto RW0, 2-entry in-order read response buffer.
// Ports: clock, reset_n (async low), bus (slave: wr/rd/resp channels),
// init_done, RW0_addr/en/wmode/wmask/wdata (array drive), RW0_rdata.
module array_20_ctrl #(
  parameter int DEPTH   = 4096,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 192,
  parameter int MASK_W  = 16,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  array_20_ctrl_if.slave    bus,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              infl_q, infl_d;
  logic              head_q, head_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];

  logic       run;
  logic [1:0] occ;
  logic [1:0] occ_n;
  logic       rd_elig;
  logic       rv;
  logic       wv;
  logic       grant_rd;
  logic       conflict;
  logic       wr_rdy;
  logic       wr_fire;
  logic       rd_fire;
  logic       resp_vld;
  logic       resp_fire;
  logic       sweep;
  logic       tail;

  assign run = (state_q == S_RUN);

  // Credit counts both buffered data and the read whose data lands
  // next cycle, so the buffer can never overflow.
  assign occ       = bcnt_q + {1'b0, infl_q};
  assign resp_vld  = (bcnt_q != 2'd0);
  assign resp_fire = resp_vld & bus.resp_ready;
  assign occ_n     = occ - {1'b0, resp_fire};
  assign rd_elig   = (occ_n < 2'd2);

  assign rv       = run & bus.rd_valid & rd_elig;
  assign wv       = run & bus.wr_valid;
  assign conflict = rv & wv;
  // last_q=0: write wins the next conflict.
  assign grant_rd = rv & (~wv | last_q);

  assign wr_rdy  = run & ~grant_rd;
  assign wr_fire = bus.wr_valid & wr_rdy;
  assign rd_fire = grant_rd;

  assign bus.wr_ready   = wr_rdy;
  assign bus.rd_ready   = grant_rd;
  assign bus.resp_valid = resp_vld;
  assign bus.resp_data  = buf_q[head_q];
  assign init_done      = run;

  // reset_n gates the sweep so RW0 is idle while reset is held.
  assign sweep = (state_q == S_INIT) & INIT_EN & reset_n;
  assign tail  = head_q ^ bcnt_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (!INIT_EN || cnt_q == LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (conflict) last_d = ~grant_rd;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    RW0_en    = 1'b0;
    RW0_addr  = '0;
    RW0_wmode = 1'b0;
    RW0_wmask = '0;
    RW0_wdata = '0;
    unique case (1'b1)
      sweep: begin
        RW0_en    = 1'b1;
        RW0_addr  = cnt_q;
        RW0_wmode = 1'b1;
        RW0_wmask = '1;
      end
      wr_fire: begin
        RW0_en    = 1'b1;
        RW0_addr  = bus.wr_addr;
        RW0_wmode = 1'b1;
        RW0_wmask = bus.wr_mask;
        RW0_wdata = bus.wr_data;
      end
      rd_fire: begin
        RW0_en    = 1'b1;
        RW0_addr  = bus.rd_addr;
      end
      default: ;
    endcase
  end

  // Array data is valid the cycle after the read: capture then.
  always_comb begin
    infl_d = rd_fire;
    head_d = head_q ^ resp_fire;
    bcnt_d = bcnt_q + {1'b0, infl_q}
           - {1'b0, resp_fire};
    buf_d  = buf_q;
    if (infl_q) buf_d[tail] = RW0_rdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      infl_q   <= 1'b0;
      head_q   <= 1'b0;
      bcnt_q   <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      infl_q   <= infl_d;
      head_q   <= head_d;
      bcnt_q   <= bcnt_d;
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
    end
  end

endmodule
